hub75_bcm_driver: RTL

Parametrised HUB75 LED-matrix scan driver with binary-code-modulation (BCM) colour depth. It reads two pixels per column (upper and lower panel halves) from an external pixel source over a one-cycle-latency read port. For every row it shifts each bit-plane into the panel, latches it, and displays it for a binary-weighted on-time. Everything runs in one clock domain: a tick enable replaces the divided clock, and all sequencing is by state machine.

---
 rtl/hub75_bcm_driver.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/hub75_bcm_driver.sv
// HUB75 LED-matrix scan driver with binary-code-modulation colour planes, sequenced by a tick-enabled FSM.
// Optional macro BRIGHT_EN adds an 8-bit `bright` input that trims the NOE-low part of each display window.
module hub75_bcm_driver #(
  parameter int unsigned COLS     = 64,
  parameter int unsigned ROW_BITS = 5,
  parameter int unsigned BPC      = 8,
  parameter int unsigned CLK_DIV  = 3,
  parameter int unsigned BASE_ON  = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
`ifdef BRIGHT_EN
  input  logic [7:0]                        bright,
`endif
  output logic [ROW_BITS+$clog2(COLS)-1:0]  pix_addr,
  output logic                              pix_rd,
  input  logic [6*BPC-1:0]                  pix_data,
  output logic                              LP_CLK,
  output logic                              LATCH,
  output logic                              NOE,
  output logic [ROW_BITS-1:0]               ROW,
  output logic [2:0]                        RGB0,
  output logic [2:0]                        RGB1,
  output logic                              frame_start
);

  localparam int unsigned CW  = $clog2(COLS);
  localparam int unsigned AW  = ROW_BITS + CW;
  localparam int unsigned PW  = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int unsigned DW  = $clog2(BASE_ON << (BPC - 1)) + 1;
  localparam int unsigned DVW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISP} state_t;

  state_t              r_state, w_state_nxt;
  logic [DVW-1:0]      r_div;
  logic                w_tick;
  logic [ROW_BITS-1:0] r_row, w_row_nxt;
  logic [PW-1:0]       r_plane, w_plane_nxt;
  logic [CW-1:0]       r_col, w_col_nxt;
  logic                r_phase, w_phase_nxt;
  logic [DW-1:0]       r_disp, w_disp_nxt, w_disp_last;
  logic                w_rd, w_fs;
  logic                r_rd_q;
  logic                w_lp, w_latch, w_noe;
  logic [BPC-1:0]      w_up_r, w_up_g, w_up_b, w_lo_r, w_lo_g, w_lo_b;

  logic [AW-1:0]       r_pix_addr;
  logic                r_pix_rd, r_frame_start, r_lp_clk, r_latch, r_noe;
  logic [ROW_BITS-1:0] r_row_out;
  logic [2:0]          r_rgb0, r_rgb1;

  assign w_tick      = (r_div == DVW'(CLK_DIV - 1));
  assign w_disp_last = (DW'(BASE_ON) << r_plane) - DW'(1);

  assign w_up_r = pix_data[6*BPC-1 -: BPC];
  assign w_up_g = pix_data[5*BPC-1 -: BPC];
  assign w_up_b = pix_data[4*BPC-1 -: BPC];
  assign w_lo_r = pix_data[3*BPC-1 -: BPC];
  assign w_lo_g = pix_data[2*BPC-1 -: BPC];
  assign w_lo_b = pix_data[BPC-1:0];

  // Scan sequencer: every counter and the state move only on a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_plane_nxt = r_plane;
    w_col_nxt   = r_col;
    w_phase_nxt = r_phase;
    w_disp_nxt  = r_disp;
    w_rd        = 1'b0;
    w_fs        = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            w_row_nxt   = '0;
            w_plane_nxt = '0;
            w_col_nxt   = '0;
            w_phase_nxt = 1'b0;
            w_rd        = 1'b1;
            w_fs        = 1'b1;
            w_state_nxt = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!r_phase) begin
            w_phase_nxt = 1'b1;
          end else begin
            w_phase_nxt = 1'b0;
            if (r_col == CW'(COLS - 1)) begin
              w_col_nxt   = '0;
              w_state_nxt = S_LATCH;
            end else begin
              w_col_nxt = r_col + CW'(1);
              w_rd      = 1'b1;
            end
          end
        end
        S_LATCH: begin
          w_disp_nxt  = '0;
          w_state_nxt = S_DISP;
        end
        S_DISP: begin
          if (r_disp == w_disp_last) begin
            w_disp_nxt = '0;
            if (!en) begin
              w_row_nxt   = '0;
              w_plane_nxt = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_col_nxt   = '0;
              w_phase_nxt = 1'b0;
              w_rd        = 1'b1;
              w_state_nxt = S_SHIFT;
              if (r_plane == PW'(BPC - 1)) begin
                w_plane_nxt = '0;
                w_row_nxt   = r_row + ROW_BITS'(1);
                w_fs        = (r_row == '1);
              end else begin
                w_plane_nxt = r_plane + PW'(1);
              end
            end
          end else begin
            w_disp_nxt = r_disp + DW'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_lp    = (r_state == S_SHIFT) && r_phase;
  assign w_latch = (r_state == S_LATCH);

`ifdef BRIGHT_EN
  localparam int unsigned MW = DW + 9;
  logic [MW-1:0] w_on_prod, w_on_ticks;
  assign w_on_prod  = (MW'(BASE_ON) << r_plane) * (MW'(bright) + MW'(1));
  assign w_on_ticks = w_on_prod >> 8;
  assign w_noe      = !((r_state == S_DISP) && (MW'(r_disp) < w_on_ticks));
`else
  assign w_noe      = (r_state != S_DISP);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Panel strobes trail the state by one clk so RGB settles before LP_CLK rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div         <= '0;
      r_row         <= '0;
      r_plane       <= '0;
      r_col         <= '0;
      r_phase       <= 1'b0;
      r_disp        <= '0;
      r_rd_q        <= 1'b0;
      r_pix_addr    <= '0;
      r_pix_rd      <= 1'b0;
      r_frame_start <= 1'b0;
      r_lp_clk      <= 1'b0;
      r_latch       <= 1'b0;
      r_noe         <= 1'b1;
      r_row_out     <= '0;
      r_rgb0        <= '0;
      r_rgb1        <= '0;
    end else begin
      r_div         <= w_tick ? '0 : r_div + DVW'(1);
      r_row         <= w_row_nxt;
      r_plane       <= w_plane_nxt;
      r_col         <= w_col_nxt;
      r_phase       <= w_phase_nxt;
      r_disp        <= w_disp_nxt;
      r_pix_rd      <= w_rd;
      r_frame_start <= w_fs;
      r_rd_q        <= r_pix_rd;
      if (w_rd) r_pix_addr <= {w_row_nxt, w_col_nxt};
      if (r_rd_q) begin
        r_rgb0 <= {w_up_r[r_plane], w_up_g[r_plane], w_up_b[r_plane]};
        r_rgb1 <= {w_lo_r[r_plane], w_lo_g[r_plane], w_lo_b[r_plane]};
      end
      r_lp_clk <= w_lp;
      r_latch  <= w_latch;
      r_noe    <= w_noe;
      if (w_latch) r_row_out <= r_row;
    end
  end

  assign pix_addr    = r_pix_addr;
  assign pix_rd      = r_pix_rd;
  assign LP_CLK      = r_lp_clk;
  assign LATCH       = r_latch;
  assign NOE         = r_noe;
  assign ROW         = r_row_out;
  assign RGB0        = r_rgb0;
  assign RGB1        = r_rgb1;
  assign frame_start = r_frame_start;

endmodule
